// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_stage
// Brief    : Decode/issue stage ahead of a 16-entry register file. Holds one
//            instruction, drives rs1/rs2 read addresses, blocks read-after-
//            write hazards with a pending-write scoreboard and issues a
//            registered execute packet aligned with the register file data.
// Options  : STALL_COUNT_EN adds a saturating 16-bit stall_count output.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_stage #(
    parameter int NUM_REG = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [3:0]         ex_opcode,
    output logic [3:0]         ex_rd,
    output logic [3:0]         ex_imm,
    output logic               ex_wen,
    input  logic               wb_valid,
    input  logic [3:0]         wb_rd,
    output logic               halted
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t               state;
    state_t               next_state;
    logic [INSTR_W-1:0]   slot;
    logic [NUM_REG-1:0]   scoreboard;
    logic [NUM_REG-1:0]   scoreboard_next;

    logic [3:0]           opcode;
    logic [3:0]           dst;
    logic [3:0]           src1;
    logic [3:0]           src2;
    logic                 reads_rs1;
    logic                 reads_rs2;
    logic                 writes_rd;
    logic                 holding;
    logic                 blocked;
    logic                 ex_free;
    logic                 issue;
    logic                 transfer;
    logic                 load_slot;

    // Field extraction and opcode class decode of the held instruction.
    always_comb begin
        opcode    = slot[15:12];
        dst       = slot[11:8];
        src1      = slot[7:4];
        src2      = slot[3:0];
        reads_rs1 = (opcode != 4'h0) && (opcode != OP_HALT);
        reads_rs2 = ((opcode >= 4'h1) && (opcode <= 4'h7)) ||
                    ((opcode >= 4'hC) && (opcode <= 4'hE));
        writes_rd = (opcode >= 4'h1) && (opcode <= 4'hB);
    end

    // Hazard check and issue decision; reset suppresses any issue or transfer.
    always_comb begin
        holding = (state == S_HOLD);
        blocked = holding && ((reads_rs1 && scoreboard[src1]) ||
                              (reads_rs2 && scoreboard[src2]));
        ex_free = !ex_valid || ex_ready;
        issue   = reset && holding && !blocked && ex_free;
        rs1     = (reset && holding) ? src1 : 4'h0;
        rs2     = (reset && holding) ? src2 : 4'h0;
        halted  = (state == S_HALTED);
    end

    // Next-state, handshake and slot-load control.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        load_slot   = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = reset;
                if (instr_valid && reset) begin
                    next_state = S_HOLD;
                    load_slot  = 1'b1;
                end
            end
            S_HOLD: begin
                if (issue) begin
                    if (opcode == OP_HALT) begin
                        // A transfer offered alongside HALT issue is refused.
                        next_state = S_HALTED;
                    end else begin
                        instr_ready = 1'b1;
                        if (instr_valid) begin
                            load_slot = 1'b1;
                        end else begin
                            next_state = S_IDLE;
                        end
                    end
                end
            end
            S_HALTED: begin
                next_state = S_HALTED;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        transfer = instr_valid && instr_ready;
    end

    // Scoreboard update: retire clears first, issue set wins on the same register.
    always_comb begin
        scoreboard_next = scoreboard;
        if (wb_valid) begin
            scoreboard_next[wb_rd] = 1'b0;
        end
        if (issue && writes_rd) begin
            scoreboard_next[dst] = 1'b1;
        end
    end

    // State, decode slot and scoreboard registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            slot       <= '0;
            scoreboard <= '0;
        end else begin
            state      <= next_state;
            scoreboard <= scoreboard_next;
            if (load_slot && transfer) begin
                slot <= instr;
            end
        end
    end

    // Execute packet: loaded on issue, held until consumed by ex_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_opcode <= 4'h0;
            ex_rd     <= 4'h0;
            ex_imm    <= 4'h0;
            ex_wen    <= 1'b0;
        end else if (issue) begin
            ex_valid  <= 1'b1;
            ex_opcode <= opcode;
            ex_rd     <= dst;
            ex_imm    <= src2;
            ex_wen    <= writes_rd;
        end else if (ex_ready) begin
            ex_valid  <= 1'b0;
        end
    end

`ifdef STALL_COUNT_EN
    // Saturating count of HOLD cycles where only the scoreboard blocks issue.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= 16'h0000;
        end else if (blocked && ex_free && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/issue stage directly upstream of the 16-entry register file.
- Accepts 16-bit instruction words over a valid/ready handshake and splits them into fields.
- Drives the register file read addresses rs1/rs2 and blocks read-after-write hazards with a pending-write scoreboard.
- Issues a registered execute packet that is cycle-aligned with the register file's registered reg1/reg2 outputs, one cycle after the addresses are driven.

Parameters:
- NUM_REG, 16, register count; scoreboard width.
- INSTR_W, 16, instruction width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- instr_valid  in  1  upstream instruction present.
- instr  in  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
- instr_ready  out  1  stage can accept an instruction this cycle.
- rs1  out  4  register file read address 1.
- rs2  out  4  register file read address 2.
- ex_valid  out  1  execute packet valid; reg1/reg2 from the register file are valid in the same cycle.
- ex_ready  in  1  execute stage consumes the packet.
- ex_opcode  out  4  issued opcode.
- ex_rd  out  4  issued destination register.
- ex_imm  out  4  issued imm4.
- ex_wen  out  1  issued instruction writes rd.
- wb_valid  in  1  writeback retiring a register write.
- wb_rd  in  4  register being retired.
- halted  out  1  HALT has issued.

Behaviour:
- Opcode classes:
  - 0x0 NOP: no sources, no write.
  - 0x1-0x7 R-type: reads rs1 and rs2, writes rd.
  - 0x8-0xB I-type: reads rs1, imm4 taken from [3:0], writes rd.
  - 0xC-0xE branch: reads rs1 and rs2, no write.
  - 0xF HALT: no sources, no write.
- Reset (reset==0 at an edge): slot empty, scoreboard cleared, state IDLE. Outputs: ex_valid=0, ex_opcode=0, ex_rd=0, ex_imm=0, ex_wen=0, rs1=0, rs2=0, halted=0, instr_ready=0 during the reset cycle. Reset overrides every other event, including a mid-handshake transfer.
- States:
  - IDLE: no instruction held.
  - HOLD: one instruction held in the decode slot.
  - HALTED: terminal.
- Issue condition: state HOLD and no source register pending in the scoreboard and (!ex_valid || ex_ready).
- rs1/rs2 are combinational from the held instruction's [7:4]/[3:0]; they are 0 when the slot is empty.
- On an issue edge, the ex_* fields are loaded and ex_valid=1. The register file captures reg1/reg2 at the same edge, so data and packet align with 1-cycle issue latency.
- ex_valid stays 1 with ex_* stable until ex_ready==1 at an edge; it then clears unless a new issue happens in that same cycle.
- instr_ready = (state==IDLE) || (state==HOLD && issuing this cycle). A transfer occurs at an edge when instr_valid && instr_ready. Back-to-back issue gives a throughput of 1 instruction per clock.
- Transitions:
  - IDLE to HOLD on transfer.
  - HOLD stays HOLD on issue with a new transfer.
  - HOLD to IDLE on issue with no transfer.
  - HOLD to HALTED when HALT issues. In HALTED, instr_ready=0 and halted=1 until reset; a transfer offered in the HALT-issue cycle is refused.
- Scoreboard (NUM_REG bits):
  - Bit rd is set on issue when ex_wen.
  - Bit wb_rd is cleared at an edge when wb_valid.
  - Same-edge set and clear of the same register: set wins.
  - No bypass: a bit cleared at edge N unblocks issue only in cycle N+1, because the register file writes and reads on the same edge.
- Unused source fields (NOP, HALT, imm4) are never checked against the scoreboard.
- A wb_valid for a register with no pending write is harmless and leaves the bit 0.

Optional Feature:
- Macro STALL_COUNT_EN.
- When defined:
  - Adds output stall_count (16 bits): saturating count of cycles spent in HOLD with issue blocked only by the scoreboard.
  - Holds at 0xFFFF once saturated; reset to 0.
- When undefined: the port and the counter are absent.

Test Plan:
- Reset, then instr 0x1312 (ADD r3=r1,r2) with ex_ready=1 → instr_ready=1 while IDLE; rs1=1, rs2=2 in the hold cycle; next cycle ex_valid=1, ex_rd=3, ex_wen=1; scoreboard bit 3 set.
- 0x1312 then 0x1430 (reads r3) → second instruction stalls in HOLD with instr_ready=0. wb_valid with wb_rd=3 at edge N → issues at edge N+1; stall_count=stall cycles when STALL_COUNT_EN is defined.
- Issue 0x8525 with ex_ready=0 for 3 cycles → ex_valid=1 with ex_opcode=8, ex_rd=5, ex_imm=5 held stable; next instruction not issued; it issues the cycle ex_ready=1.
- Same-edge issue of a write to r6 and wb_valid with wb_rd=6 → bit 6 remains set.
- Stream NOP, 0xF000, 0x1111 → halted=1 after HALT issues; 0x1111 is never accepted; reset returns to IDLE with halted=0.
- Pull reset low while an instruction is held and ex_valid=1 → next edge: ex_valid=0, scoreboard clear, state IDLE.
